// File: rtl/rtc_bus_bridge_if.sv
// rtc_bus_bridge_if
// PicoBlaze port bus as seen by an output-side peripheral.
//   port_id      : port address from the processor
//   out_port     : write data from the processor
//   write_strobe : one-cycle qualifier for port_id/out_port
//   in_port      : registered read-back from the peripheral
// The processor side uses the master modport. The peripheral side uses the slave modport.
interface rtc_bus_bridge_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic [7:0] in_port;

  modport master (
    output port_id,
    output out_port,
    output write_strobe,
    input  in_port
  );

  modport slave (
    input  port_id,
    input  out_port,
    input  write_strobe,
    output in_port
  );
endinterface

// File: rtl/rtc_bus_bridge.sv
// rtc_bus_bridge
// Converts PicoBlaze OUTPUT writes into address-then-data transactions on
// an 8-bit multiplexed RTC bus. Read data and busy status are returned on
// in_port.
//
// Port map (writes need write_strobe=1):
//   0x01 : addr_reg  <= out_port (accepted at any time)
//   0x02 : wdata_reg <= out_port and start a write (accepted in IDLE only)
//   0x03 : start a read (accepted in IDLE only)
// Read-back (port_id sampled every cycle):
//   0x04 : {7'b0, busy}
//   0x05 : rdata_reg
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous reset, active low
//   pb    : PicoBlaze port bus (slave side)
//   ad    : multiplexed address/data bus, high-Z when not driven
//   cs_n  : chip select, active low
//   wr_n  : write strobe, active low
//   rd_n  : read strobe, active low
//   a_d   : 0 = address phase, 1 = data phase
//   busy  : a transaction is in progress
module rtc_bus_bridge #(
  parameter int PULSE_CYC = 10
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_bridge_if.slave    pb,
  inout  wire  [7:0]         ad,
  output logic               cs_n,
  output logic               wr_n,
  output logic               rd_n,
  output logic               a_d,
  output logic               busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_GAP,
    ST_DATA_SETUP,
    ST_DATA_STROBE,
    ST_DATA_HOLD
  } state_t;

  localparam logic [7:0] LAST_CNT    = 8'(PULSE_CYC - 1);
  localparam logic [7:0] PORT_ADDR   = 8'h01;
  localparam logic [7:0] PORT_WRITE  = 8'h02;
  localparam logic [7:0] PORT_READ   = 8'h03;
  localparam logic [7:0] PORT_STATUS = 8'h04;
  localparam logic [7:0] PORT_RDATA  = 8'h05;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_reg_q, addr_reg_d;
  logic [7:0] wdata_reg_q, wdata_reg_d;
  logic [7:0] rdata_reg_q, rdata_reg_d;
  logic [7:0] addr_lat_q, addr_lat_d;
  logic       is_read_q, is_read_d;
  logic [7:0] in_port_q, in_port_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       a_d_q, a_d_d;
  logic       ad_oe_q, ad_oe_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       busy_q, busy_d;
  logic       phase_done;

  // Next state, datapath registers and bus outputs. The bus outputs are
  // decoded from the next state so that they are registered and still line
  // up with the state they belong to. As a result, cs_n falls on the same edge
  // that enters ADDR_SETUP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_reg_d  = addr_reg_q;
    wdata_reg_d = wdata_reg_q;
    rdata_reg_d = rdata_reg_q;
    addr_lat_d  = addr_lat_q;
    is_read_d   = is_read_q;
    phase_done  = (cnt_q == LAST_CNT);

    if (pb.write_strobe && pb.port_id == PORT_ADDR) begin
      addr_reg_d = pb.out_port;
    end

    if (state_q == ST_IDLE) begin
      cnt_d = 8'd0;
      if (pb.write_strobe && pb.port_id == PORT_WRITE) begin
        wdata_reg_d = pb.out_port;
        addr_lat_d  = addr_reg_q;
        is_read_d   = 1'b0;
        state_d     = ST_ADDR_SETUP;
      end else if (pb.write_strobe && pb.port_id == PORT_READ) begin
        addr_lat_d  = addr_reg_q;
        is_read_d   = 1'b1;
        state_d     = ST_ADDR_SETUP;
      end
    end else if (phase_done) begin
      cnt_d = 8'd0;
      case (state_q)
        ST_ADDR_SETUP:  state_d = ST_ADDR_STROBE;
        ST_ADDR_STROBE: state_d = ST_ADDR_HOLD;
        ST_ADDR_HOLD:   state_d = ST_GAP;
        ST_GAP:         state_d = ST_DATA_SETUP;
        ST_DATA_SETUP:  state_d = ST_DATA_STROBE;
        ST_DATA_STROBE: state_d = ST_DATA_HOLD;
        default:        state_d = ST_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // Capture read data on the last strobe cycle, while rd_n is still low.
    if (state_q == ST_DATA_STROBE && phase_done && is_read_q) begin
      rdata_reg_d = ad;
    end

    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    a_d_d    = 1'b0;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    case (state_d)
      ST_ADDR_SETUP, ST_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_lat_d;
      end
      ST_ADDR_STROBE: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_lat_d;
      end
      ST_GAP: begin
        a_d_d = 1'b1;
      end
      ST_DATA_SETUP, ST_DATA_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b1;
        ad_oe_d  = !is_read_d;
        ad_out_d = is_read_d ? 8'h00 : wdata_reg_d;
      end
      ST_DATA_STROBE: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b1;
        wr_n_d   = is_read_d;
        rd_n_d   = !is_read_d;
        ad_oe_d  = !is_read_d;
        ad_out_d = is_read_d ? 8'h00 : wdata_reg_d;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);

    // Read-back uses the current port_id. in_port therefore trails port_id by one cycle.
    case (pb.port_id)
      PORT_STATUS: in_port_d = {7'b0, busy_q};
      PORT_RDATA:  in_port_d = rdata_reg_q;
      default:     in_port_d = 8'h00;
    endcase
  end

  // All state and outputs. Asserting reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      addr_reg_q  <= 8'h00;
      wdata_reg_q <= 8'h00;
      rdata_reg_q <= 8'h00;
      addr_lat_q  <= 8'h00;
      is_read_q   <= 1'b0;
      in_port_q   <= 8'h00;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      a_d_q       <= 1'b0;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_reg_q  <= addr_reg_d;
      wdata_reg_q <= wdata_reg_d;
      rdata_reg_q <= rdata_reg_d;
      addr_lat_q  <= addr_lat_d;
      is_read_q   <= is_read_d;
      in_port_q   <= in_port_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      a_d_q       <= a_d_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      busy_q      <= busy_d;
    end
  end

  assign ad         = ad_oe_q ? ad_out_q : 8'bz;
  assign cs_n       = cs_n_q;
  assign wr_n       = wr_n_q;
  assign rd_n       = rd_n_q;
  assign a_d        = a_d_q;
  assign busy       = busy_q;
  assign pb.in_port = in_port_q;

endmodule

// File: tb/tb_rtc_bus_bridge.sv
// tb_rtc_bus_bridge
// Directed bench for rtc_bus_bridge with PULSE_CYC=2. One bus phase is two
// cycles, and a transaction spans cycles 0..13 after the start edge.
// Phase index: 0 ADDR_SETUP, 1 ADDR_STROBE, 2 ADDR_HOLD, 3 GAP,
// 4 DATA_SETUP, 5 DATA_STROBE, 6 DATA_HOLD, 7 IDLE.
// Whenever the bridge must release ad, the bench drives its own value. If
// that value reads back unchanged, the bridge is not driving the bus.
module tb_rtc_bus_bridge;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire  [7:0] ad;
  logic       cs_n, wr_n, rd_n, a_d, busy;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_ad = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  rtc_bus_bridge_if pb();

  assign ad = tb_drv ? tb_ad : 8'bz;

  rtc_bus_bridge #(.PULSE_CYC(P)) dut (
    .clk   (clk),
    .reset (reset),
    .pb    (pb),
    .ad    (ad),
    .cs_n  (cs_n),
    .wr_n  (wr_n),
    .rd_n  (rd_n),
    .a_d   (a_d),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pb_write(input logic [7:0] port, input logic [7:0] data);
    pb.port_id      = port;
    pb.out_port     = data;
    pb.write_strobe = 1'b1;
    tick();
    pb.write_strobe = 1'b0;
    pb.port_id      = 8'h00;
    pb.out_port     = 8'h00;
  endtask

  // Value the bench drives when the bridge must float ad.
  function automatic logic [7:0] tb_value(int phase, bit rd, logic [7:0] rval);
    return (rd && phase >= 4 && phase <= 6) ? rval : 8'hC3;
  endfunction

  function automatic bit tb_drives(int phase, bit rd);
    return (phase == 3) || (phase == 7) || (rd && phase >= 4 && phase <= 6);
  endfunction

  task automatic bus_drive(input int phase, input bit rd, input logic [7:0] rval);
    tb_drv = tb_drives(phase, rd);
    tb_ad  = tb_value(phase, rd, rval);
  endtask

  // Reference pin values {busy, cs_n, wr_n, rd_n, a_d, ad} for one phase.
  function automatic logic [12:0] exp_bus(int phase, bit rd, logic [7:0] addr,
                                          logic [7:0] data, logic [7:0] rval);
    logic       b, cs, wr, rdn, adp;
    logic [7:0] v;
    b   = (phase < 7);
    cs  = (phase == 3) || (phase == 7);
    wr  = !((phase == 1) || (phase == 5 && !rd));
    rdn = !(phase == 5 && rd);
    adp = (phase >= 3) && (phase <= 6);
    if (phase <= 2)                 v = addr;
    else if (phase >= 4 && phase <= 6 && !rd) v = data;
    else                            v = tb_value(phase, rd, rval);
    return {b, cs, wr, rdn, adp, v};
  endfunction

  task automatic test_reset();
    #22;
    n_vec++;
    if ({busy, cs_n, wr_n, rd_n, a_d} !== 5'b01110) begin
      n_err++;
      $display("[TB] FAIL reset_pins: got %b expected 01110", {busy, cs_n, wr_n, rd_n, a_d});
    end
    n_vec++;
    if (pb.in_port !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_in_port: got %h expected 00", pb.in_port);
    end
    tb_drv = 1'b1; tb_ad = 8'hA5; #1;
    n_vec++;
    if (ad !== 8'hA5) begin
      n_err++;
      $display("[TB] FAIL reset_ad_released: got %h expected a5", ad);
    end
    tb_drv = 1'b0;
    reset = 1'b1;
    tick();
    pb.port_id = 8'h05;
    tick();
    n_vec++;
    if (pb.in_port !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL reset_rdata: got %h expected 00", pb.in_port);
    end
    pb.port_id = 8'h00;
    tick();
  endtask

  task automatic test_write();
    logic [12:0] got, exp;
    int phase;
    pb_write(8'h01, 8'h21);
    pb_write(8'h02, 8'h59);
    for (int c = 0; c <= 14; c++) begin
      phase = (c < 14) ? c / 2 : 7;
      bus_drive(phase, 1'b0, 8'h00);
      #1;
      got = {busy, cs_n, wr_n, rd_n, a_d, ad};
      exp = exp_bus(phase, 1'b0, 8'h21, 8'h59, 8'h00);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL write c=%0d: got %h expected %h", c, got, exp);
      end
      tick();
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_read_status();
    logic [12:0] got, exp;
    int phase;
    pb_write(8'h01, 8'h33);
    pb_write(8'h03, 8'hFF);
    pb.port_id = 8'h04;
    for (int c = 0; c <= 14; c++) begin
      phase = (c < 14) ? c / 2 : 7;
      bus_drive(phase, 1'b1, 8'h37);
      #1;
      got = {busy, cs_n, wr_n, rd_n, a_d, ad};
      exp = exp_bus(phase, 1'b1, 8'h33, 8'h00, 8'h37);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL read c=%0d: got %h expected %h", c, got, exp);
      end
      if (c == 7) begin
        n_vec++;
        if (pb.in_port !== 8'h01) begin
          n_err++;
          $display("[TB] FAIL status_busy: got %h expected 01", pb.in_port);
        end
      end
      tick();
    end
    tb_drv = 1'b0;
    #1;
    n_vec++;
    if (pb.in_port !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL status_idle: got %h expected 00", pb.in_port);
    end
    pb.port_id = 8'h05;
    tick();
    n_vec++;
    if (pb.in_port !== 8'h37) begin
      n_err++;
      $display("[TB] FAIL read_data: got %h expected 37", pb.in_port);
    end
    pb.port_id = 8'h00;
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [12:0] got, exp;
    int phase;
    int extra;
    pb_write(8'h01, 8'h10);
    pb_write(8'h02, 8'h5A);
    for (int c = 0; c <= 14; c++) begin
      phase = (c < 14) ? c / 2 : 7;
      if (c == 4) begin
        pb.port_id = 8'h02; pb.out_port = 8'hAA; pb.write_strobe = 1'b1;
      end
      bus_drive(phase, 1'b0, 8'h00);
      #1;
      got = {busy, cs_n, wr_n, rd_n, a_d, ad};
      exp = exp_bus(phase, 1'b0, 8'h10, 8'h5A, 8'h00);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL busy_start c=%0d: got %h expected %h", c, got, exp);
      end
      tick();
      pb.write_strobe = 1'b0; pb.port_id = 8'h00; pb.out_port = 8'h00;
    end
    tb_drv = 1'b0;
    extra = 0;
    repeat (20) begin
      if (cs_n !== 1'b1 || busy !== 1'b0) extra++;
      tick();
    end
    n_vec++;
    if (extra != 0) begin
      n_err++;
      $display("[TB] FAIL no_second_cycle: got %0d active cycles expected 0", extra);
    end
    pb.port_id = 8'h05;
    tick();
    n_vec++;
    if (pb.in_port !== 8'h37) begin
      n_err++;
      $display("[TB] FAIL rdata_kept: got %h expected 37", pb.in_port);
    end
    pb.port_id = 8'h00;
    tick();
  endtask

  task automatic test_addr_change();
    logic [12:0] got, exp;
    int phase;
    pb_write(8'h01, 8'h11);
    pb_write(8'h02, 8'h66);
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c <= 14; c++) begin
        phase = (c < 14) ? c / 2 : 7;
        if (t == 0 && c == 8) begin
          pb.port_id = 8'h01; pb.out_port = 8'h44; pb.write_strobe = 1'b1;
        end
        bus_drive(phase, 1'b0, 8'h00);
        #1;
        got = {busy, cs_n, wr_n, rd_n, a_d, ad};
        exp = (t == 0) ? exp_bus(phase, 1'b0, 8'h11, 8'h66, 8'h00)
                       : exp_bus(phase, 1'b0, 8'h44, 8'h77, 8'h00);
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("[TB] FAIL addr_change t=%0d c=%0d: got %h expected %h", t, c, got, exp);
        end
        tick();
        pb.write_strobe = 1'b0; pb.port_id = 8'h00; pb.out_port = 8'h00;
      end
      tb_drv = 1'b0;
      if (t == 0) pb_write(8'h02, 8'h77);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got, exp;
    int phase;
    pb_write(8'h01, 8'h0F);
    pb_write(8'h02, 8'h9D);
    for (int c = 0; c <= 29; c++) begin
      if (c < 14)      phase = c / 2;
      else if (c == 14) phase = 7;
      else if (c < 29)  phase = (c - 15) / 2;
      else              phase = 7;
      if (c == 13) begin
        pb.port_id = 8'h02; pb.out_port = 8'hBB; pb.write_strobe = 1'b1;
      end else if (c == 14) begin
        pb.port_id = 8'h02; pb.out_port = 8'hCC; pb.write_strobe = 1'b1;
      end
      bus_drive(phase, 1'b0, 8'h00);
      #1;
      got = {busy, cs_n, wr_n, rd_n, a_d, ad};
      exp = exp_bus(phase, 1'b0, 8'h0F, (c < 15) ? 8'h9D : 8'hCC, 8'h00);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL back_to_back c=%0d: got %h expected %h", c, got, exp);
      end
      tick();
      pb.write_strobe = 1'b0; pb.port_id = 8'h00; pb.out_port = 8'h00;
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [12:0] got, exp;
    int phase;
    int active;
    pb_write(8'h01, 8'h12);
    pb_write(8'h02, 8'h34);
    for (int c = 0; c <= 10; c++) begin
      phase = c / 2;
      bus_drive(phase, 1'b0, 8'h00);
      #1;
      got = {busy, cs_n, wr_n, rd_n, a_d, ad};
      exp = exp_bus(phase, 1'b0, 8'h12, 8'h34, 8'h00);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("[TB] FAIL pre_reset c=%0d: got %h expected %h", c, got, exp);
      end
      if (c < 10) tick();
    end
    #1;
    reset = 1'b0;
    tb_drv = 1'b1; tb_ad = 8'h5A;
    #1;
    got = {busy, cs_n, wr_n, rd_n, a_d, ad};
    n_vec++;
    if (got !== {5'b01110, 8'h5A}) begin
      n_err++;
      $display("[TB] FAIL reset_mid: got %h expected %h", got, {5'b01110, 8'h5A});
    end
    tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    tick();
    active = 0;
    repeat (30) begin
      if (busy !== 1'b0 || cs_n !== 1'b1 || wr_n !== 1'b1 || rd_n !== 1'b1) active++;
      tick();
    end
    n_vec++;
    if (active != 0) begin
      n_err++;
      $display("[TB] FAIL no_resume: got %0d active cycles expected 0", active);
    end
  endtask

  initial begin
    pb.port_id      = 8'h00;
    pb.out_port     = 8'h00;
    pb.write_strobe = 1'b0;
    test_reset();
    test_write();
    test_read_status();
    test_start_while_busy();
    test_addr_change();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_bridge.md
# rtc_bus_bridge

Peripheral bridge on the output side of the PicoBlaze microcontroller. Decodes its port writes (`port_id`/`out_port`/`write_strobe`) into address-then-data transactions on an 8-bit multiplexed real-time-clock bus (`ad`, `cs_n`, `wr_n`, `rd_n`, `a_d`). Returns the read data and status to the processor through `in_port`. Lets firmware program and read RTC registers with plain OUTPUT/INPUT instructions.

## Interface
- `PULSE_CYC`, default 10: clk cycles per bus phase; legal range 1..255 (8-bit phase counter).
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `port_id` input 8: port address from the PicoBlaze.
- `out_port` input 8: data from the PicoBlaze.
- `write_strobe` input 1: one-cycle write qualifier from the PicoBlaze.
- `in_port` output 8: registered read-back to the PicoBlaze.
- `ad` inout 8: multiplexed address/data bus to the RTC; high-Z when not driven.
- `cs_n` output 1: chip select, active low.
- `wr_n` output 1: write strobe, active low.
- `rd_n` output 1: read strobe, active low.
- `a_d` output 1: bus phase select; 0 = address phase, 1 = data phase.
- `busy` output 1: a transaction is in progress.

## Operation
- Port map; a write requires `write_strobe`=1 and matching `port_id`:
  - 0x01: load `addr_reg` from `out_port`. Accepted at any time.
  - 0x02: load `wdata_reg` from `out_port` and start a write transaction. Accepted only in IDLE.
  - 0x03: start a read transaction; `out_port` is ignored. Accepted only in IDLE.
  - Any other `port_id`: no effect.
  - Starts received while not in IDLE are dropped silently.
- On start, `addr_reg` is copied to `addr_lat`. Later writes to 0x01 do not affect the transaction in flight.
- FSM states, each held for exactly `PULSE_CYC` cycles:
  - IDLE: all strobes high, `a_d`=0, `ad` high-Z.
  - ADDR_SETUP: `cs_n`=0, `a_d`=0, drive `ad`=`addr_lat`.
  - ADDR_STROBE: as ADDR_SETUP, plus `wr_n`=0.
  - ADDR_HOLD: `wr_n`=1; `cs_n`=0 and `ad` still driven.
  - GAP: `cs_n`=1, `ad` high-Z, `a_d`=1.
  - DATA_SETUP: `cs_n`=0, `a_d`=1. Write: drive `ad`=`wdata_reg`. Read: `ad` high-Z.
  - DATA_STROBE: as DATA_SETUP, plus `wr_n`=0 (write) or `rd_n`=0 (read).
  - DATA_HOLD: strobes high, `cs_n`=0; write data still driven.
  - After DATA_HOLD the FSM returns to IDLE.
- Read capture: `rdata_reg` <= `ad` on the last cycle of DATA_STROBE, while `rd_n` is still 0. Write transactions leave `rdata_reg` unchanged.
- Read-back, registered every cycle:
  - `port_id`=0x04: `in_port` <= {7'b0, `busy`}.
  - `port_id`=0x05: `in_port` <= `rdata_reg`.
  - Otherwise: `in_port` <= 0x00.
- `wr_n` and `rd_n` are never low in the same cycle. Neither is ever low while `cs_n`=1.

## Timing
- Reset values, applied asynchronously while `reset`=0: `cs_n`=`wr_n`=`rd_n`=1, `a_d`=0, `ad` high-Z, `busy`=0, `in_port`=0x00, `addr_reg`=`wdata_reg`=`rdata_reg`=0x00, FSM=IDLE, phase counter=0.
- Reset mid-transaction aborts the transaction immediately: strobes go high and `ad` is released with no glitch low. The transaction does not resume after reset is released.
- Start latency: start strobe sampled at edge N; at N+1 the FSM is in ADDR_SETUP, `busy`=1 and `cs_n`=0.
- `busy` stays high for exactly 7×`PULSE_CYC` cycles. It is 0 in the first IDLE cycle, so a new start is accepted on that cycle.
- A start whose strobe coincides with the last DATA_HOLD cycle is dropped, because the FSM is not yet in IDLE.
- `in_port` lags `port_id` by one cycle. The PicoBlaze holds `port_id` for 2 cycles on INPUT, so the timing is sufficient.
- With `PULSE_CYC`=1 every phase is one cycle; the sequence is unchanged.

## Test plan
- Write, `PULSE_CYC`=2: OUT 0x21→0x01, then OUT 0x59→0x02 -> `ad`=0x21 with `a_d`=0 and `wr_n` low for 2 cycles; then `ad`=0x59 with `a_d`=1 and `wr_n` low for 2 cycles; `busy` high for 14 cycles; `rd_n` stays 1 throughout.
- Read: OUT 0x33→0x01, then OUT any→0x03; bench drives `ad`=0x37 while `rd_n`=0 -> the bridge never drives `ad` in the data phase; after `busy` falls, `port_id`=0x05 gives `in_port`=0x37.
- Status poll: `port_id`=0x04 during a transaction -> `in_port`=0x01; after completion -> 0x00.
- Start while busy: second OUT to 0x02 with data 0xAA mid-transaction -> ignored; no second `cs_n` cycle occurs; `wdata_reg` keeps its original value.
- Address change in flight: OUT 0x44→0x01 during DATA_SETUP -> the current transaction is unaffected; the next transaction uses address 0x44.
- Reset mid-DATA_STROBE -> same cycle: `cs_n`=`wr_n`=`rd_n`=1, `ad` high-Z, `busy`=0; after release, no bus activity until a new start.
